// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - FSM control unit for the multi-cycle RV32I(+M) core
module multicycle_control_unit #(
  parameter int ALU_DECODER_IN = 3,
  parameter bit M_EXT          = 1'b1,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      CLK,
  input  logic                      rst_n,
  input  logic [6:0]                Opcode,
  input  logic [6:0]                Funct7,
  input  logic [2:0]                Funct3,
  input  logic                      IMEM_Ready,
  input  logic                      DMEM_Ready,
  input  logic                      MD_Done,
  output logic                      IMEM_Req,
  output logic                      IR_Wr_En,
  output logic                      PC_Wr_En,
  output logic                      Branch,
  output logic                      Jump,
  output logic                      DMEM_Req,
  output logic                      MEM_Wr_En,
  output logic                      Reg_Wr_En,
  output logic [1:0]                Src_to_Reg,
  output logic                      ALU_Src1_Sel,
  output logic                      ALU_Src2_Sel,
  output logic                      Sub,
  output logic [ALU_DECODER_IN-1:0] ALU_Ctrl,
  output logic                      MD_Start,
  output logic                      undef_instr,
  output logic                      bus_err,
  output logic [2:0]                state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEMACC = 3'd3,
    S_WB     = 3'd4,
    S_MDWAIT = 3'd5,
    S_TRAP   = 3'd6
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Counter only needs to reach MEM_TIMEOUT-1: the trap fires on the last waiting cycle.
  localparam int CW  = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int LIM = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;

  state_t          state_q, state_n;
  logic [CW-1:0]   cnt_q;
  logic            undef_q, bus_q;
  logic [2:0]      alu_f3;

  logic is_op, is_md, is_alu_op, is_opimm, is_lui, is_auipc;
  logic is_load, is_store, is_branch, is_jal, is_jalr, legal;
  logic mem_wait, timeout;

  assign is_op     = (Opcode == OP_R);
  assign is_md     = is_op && M_EXT && (Funct7 == 7'b0000001);
  assign is_alu_op = is_op && (Funct7 != 7'b0000001);
  assign is_opimm  = (Opcode == OP_IMM);
  assign is_lui    = (Opcode == OP_LUI);
  assign is_auipc  = (Opcode == OP_AUIPC);
  assign is_load   = (Opcode == OP_LOAD);
  assign is_store  = (Opcode == OP_STORE);
  assign is_branch = (Opcode == OP_BRANCH);
  assign is_jal    = (Opcode == OP_JAL);
  assign is_jalr   = (Opcode == OP_JALR);
  assign legal     = is_alu_op || is_md || is_opimm || is_lui || is_auipc || is_load ||
                     is_store || is_branch || is_jal || is_jalr;

  // A ready seen in the same cycle always beats the timeout.
  assign mem_wait = ((state_q == S_FETCH) && !IMEM_Ready) ||
                    ((state_q == S_MEMACC) && !DMEM_Ready);
  assign timeout  = (MEM_TIMEOUT != 0) && mem_wait && (cnt_q == CW'(LIM));

  // State register.
  always_ff @(posedge CLK) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_n;
  end

  // Wait-cycle counter, restarted whenever a new state is entered.
  always_ff @(posedge CLK) begin
    if (!rst_n || (state_n != state_q) || !mem_wait) cnt_q <= '0;
    else                                             cnt_q <= cnt_q + CW'(1);
  end

  // Sticky trap flags, cleared only by reset.
  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      undef_q <= 1'b0;
      bus_q   <= 1'b0;
    end else begin
      if ((state_q == S_DECODE) && !legal) undef_q <= 1'b1;
      if (timeout)                         bus_q   <= 1'b1;
    end
  end

  // Next-state and datapath controls; everything is quiet while reset is held.
  always_comb begin
    state_n      = state_q;
    IMEM_Req     = 1'b0;
    IR_Wr_En     = 1'b0;
    PC_Wr_En     = 1'b0;
    Branch       = 1'b0;
    Jump         = 1'b0;
    DMEM_Req     = 1'b0;
    MEM_Wr_En    = 1'b0;
    Reg_Wr_En    = 1'b0;
    Src_to_Reg   = 2'b00;
    ALU_Src1_Sel = 1'b0;
    ALU_Src2_Sel = 1'b0;
    Sub          = 1'b0;
    alu_f3       = 3'b000;
    MD_Start     = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_FETCH: begin
          IMEM_Req = 1'b1;
          if (IMEM_Ready) begin
            IR_Wr_En = 1'b1;
            PC_Wr_En = 1'b1;
            state_n  = S_DECODE;
          end else if (timeout) begin
            state_n = S_TRAP;
          end
        end
        S_DECODE: state_n = legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          ALU_Src1_Sel = is_auipc || is_jal;
          ALU_Src2_Sel = is_opimm || is_lui || is_auipc || is_load || is_store || is_jal || is_jalr;
          Sub          = (is_alu_op && (Funct3 == 3'b000) && Funct7[5]) ||
                         ((is_alu_op || is_opimm) && ((Funct3 == 3'b010) || (Funct3 == 3'b011))) ||
                         is_branch;
          alu_f3       = (is_alu_op || is_opimm) ? Funct3 : 3'b000;
          if (is_load || is_store) begin
            state_n = S_MEMACC;
          end else if (is_branch) begin
            Branch  = 1'b1;
            state_n = S_FETCH;
          end else if (is_jal || is_jalr) begin
            Jump    = 1'b1;
            state_n = S_WB;
          end else if (is_md) begin
            MD_Start = 1'b1;
            state_n  = S_MDWAIT;
          end else begin
            state_n = S_WB;
          end
        end
        S_MEMACC: begin
          DMEM_Req  = 1'b1;
          MEM_Wr_En = is_store;
          if (DMEM_Ready)   state_n = is_store ? S_FETCH : S_WB;
          else if (timeout) state_n = S_TRAP;
        end
        S_WB: begin
          Reg_Wr_En  = 1'b1;
          Src_to_Reg = is_load ? 2'b01 : (is_jal || is_jalr) ? 2'b10 : is_md ? 2'b11 : 2'b00;
          state_n    = S_FETCH;
        end
        S_MDWAIT: if (MD_Done) state_n = S_WB;
        S_TRAP:   state_n = S_TRAP;
        default:  state_n = S_FETCH;
      endcase
    end
  end

  // Wider ALU_Ctrl carries Funct7[5] in bit 3 to split SRL/SRA; upper bits stay 0.
  generate
    if (ALU_DECODER_IN == 3) begin : g_alu3
      assign ALU_Ctrl = alu_f3;
    end else if (ALU_DECODER_IN == 4) begin : g_alu4
      assign ALU_Ctrl = {(alu_f3 == 3'b101) && Funct7[5], alu_f3};
    end else begin : g_aluw
      assign ALU_Ctrl = {{(ALU_DECODER_IN-4){1'b0}}, (alu_f3 == 3'b101) && Funct7[5], alu_f3};
    end
  endgenerate

  assign undef_instr = rst_n && undef_q;
  assign bus_err     = rst_n && bus_q;
  assign state       = rst_n ? state_q : 3'd0;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb/tb_multicycle_control_unit.sv - randomized self-checking bench for multicycle_control_unit
module tb_multicycle_control_unit;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       rst_n;
  logic [6:0] Opcode, Funct7;
  logic [2:0] Funct3;
  logic       IMEM_Ready, DMEM_Ready, MD_Done;

  logic IMEM_Req, IR_Wr_En, PC_Wr_En, Branch, Jump, DMEM_Req, MEM_Wr_En, Reg_Wr_En;
  logic [1:0] Src_to_Reg;
  logic ALU_Src1_Sel, ALU_Src2_Sel, Sub, MD_Start, undef_instr, bus_err;
  logic [2:0] ALU_Ctrl, state;

  logic IMEM_Req_b, IR_Wr_En_b, PC_Wr_En_b, Branch_b, Jump_b, DMEM_Req_b, MEM_Wr_En_b, Reg_Wr_En_b;
  logic [1:0] Src_to_Reg_b;
  logic ALU_Src1_Sel_b, ALU_Src2_Sel_b, Sub_b, MD_Start_b, undef_instr_b, bus_err_b;
  logic [2:0] ALU_Ctrl_b, state_b;

  multicycle_control_unit #(.ALU_DECODER_IN(3), .M_EXT(1'b1), .MEM_TIMEOUT(15)) dut (
    .CLK(CLK), .rst_n(rst_n), .Opcode(Opcode), .Funct7(Funct7), .Funct3(Funct3),
    .IMEM_Ready(IMEM_Ready), .DMEM_Ready(DMEM_Ready), .MD_Done(MD_Done),
    .IMEM_Req(IMEM_Req), .IR_Wr_En(IR_Wr_En), .PC_Wr_En(PC_Wr_En), .Branch(Branch), .Jump(Jump),
    .DMEM_Req(DMEM_Req), .MEM_Wr_En(MEM_Wr_En), .Reg_Wr_En(Reg_Wr_En), .Src_to_Reg(Src_to_Reg),
    .ALU_Src1_Sel(ALU_Src1_Sel), .ALU_Src2_Sel(ALU_Src2_Sel), .Sub(Sub), .ALU_Ctrl(ALU_Ctrl),
    .MD_Start(MD_Start), .undef_instr(undef_instr), .bus_err(bus_err), .state(state)
  );

  multicycle_control_unit #(.ALU_DECODER_IN(3), .M_EXT(1'b0), .MEM_TIMEOUT(15)) dut_nom (
    .CLK(CLK), .rst_n(rst_n), .Opcode(Opcode), .Funct7(Funct7), .Funct3(Funct3),
    .IMEM_Ready(IMEM_Ready), .DMEM_Ready(DMEM_Ready), .MD_Done(MD_Done),
    .IMEM_Req(IMEM_Req_b), .IR_Wr_En(IR_Wr_En_b), .PC_Wr_En(PC_Wr_En_b), .Branch(Branch_b),
    .Jump(Jump_b), .DMEM_Req(DMEM_Req_b), .MEM_Wr_En(MEM_Wr_En_b), .Reg_Wr_En(Reg_Wr_En_b),
    .Src_to_Reg(Src_to_Reg_b), .ALU_Src1_Sel(ALU_Src1_Sel_b), .ALU_Src2_Sel(ALU_Src2_Sel_b),
    .Sub(Sub_b), .ALU_Ctrl(ALU_Ctrl_b), .MD_Start(MD_Start_b), .undef_instr(undef_instr_b),
    .bus_err(bus_err_b), .state(state_b)
  );

  // Control bundle: {IMEM_Req, IR_Wr, PC_Wr, Branch, Jump, DMEM_Req, MEM_Wr, Reg_Wr, Src[1:0], S1, S2, Sub, ALU[2:0], MD_Start}
  logic [16:0] ctrl;
  assign ctrl = {IMEM_Req, IR_Wr_En, PC_Wr_En, Branch, Jump, DMEM_Req, MEM_Wr_En, Reg_Wr_En,
                 Src_to_Reg, ALU_Src1_Sel, ALU_Src2_Sel, Sub, ALU_Ctrl, MD_Start};

  localparam logic [16:0] V_IREQ = 17'h10000;
  localparam logic [16:0] V_IRWR = 17'h08000;
  localparam logic [16:0] V_PCWR = 17'h04000;
  localparam logic [16:0] V_BR   = 17'h02000;
  localparam logic [16:0] V_JMP  = 17'h01000;
  localparam logic [16:0] V_DREQ = 17'h00800;
  localparam logic [16:0] V_MWR  = 17'h00400;
  localparam logic [16:0] V_RWR  = 17'h00200;
  localparam logic [16:0] V_S1   = 17'h00040;
  localparam logic [16:0] V_S2   = 17'h00020;
  localparam logic [16:0] V_SUB  = 17'h00010;
  localparam logic [16:0] V_MDS  = 17'h00001;
  localparam logic [16:0] FULL   = 17'h1FFFF;
  localparam logic [16:0] M_MASK = 17'h1FF81;

  typedef enum int {K_ALU, K_IMM, K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_MD, K_ILL} kind_t;

  int n_checks = 0;
  int n_pass   = 0;
  logic undef_exp = 1'b0;
  logic bus_exp   = 1'b0;
  int trap_len    = 3;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  function automatic logic rb();
    return 1'($urandom);
  endfunction

  function automatic kind_t classify(input logic [6:0] op, input logic [6:0] f7);
    case (op)
      7'b0110011: return (f7 == 7'b0000001) ? K_MD : K_ALU;
      7'b0010011: return K_IMM;
      7'b0110111: return K_LUI;
      7'b0010111: return K_AUIPC;
      7'b0000011: return K_LOAD;
      7'b0100011: return K_STORE;
      7'b1100011: return K_BR;
      7'b1101111: return K_JAL;
      7'b1100111: return K_JALR;
      default:    return K_ILL;
    endcase
  endfunction

  function automatic logic [6:0] opcode_of(input kind_t k);
    case (k)
      K_ALU, K_MD: return 7'b0110011;
      K_IMM:       return 7'b0010011;
      K_LUI:       return 7'b0110111;
      K_AUIPC:     return 7'b0010111;
      K_LOAD:      return 7'b0000011;
      K_STORE:     return 7'b0100011;
      K_BR:        return 7'b1100011;
      K_JAL:       return 7'b1101111;
      K_JALR:      return 7'b1100111;
      default:     return 7'b0000000;
    endcase
  endfunction

  // Expected EXEC-cycle controls, written from the per-class decode table.
  function automatic logic [16:0] exec_vec(input kind_t k, input logic [6:0] f7, input logic [2:0] f3);
    logic [16:0] v = '0;
    logic slt = (f3 == 3'd2) || (f3 == 3'd3);
    case (k)
      K_ALU:   v = {13'b0, 3'b000, 1'b0} | (17'(f3) << 1) | (((f3 == 3'd0 && f7[5]) || slt) ? V_SUB : 17'h0);
      K_IMM:   v = (17'(f3) << 1) | V_S2 | (slt ? V_SUB : 17'h0);
      K_LUI:   v = V_S2;
      K_AUIPC: v = V_S1 | V_S2;
      K_LOAD, K_STORE: v = V_S2;
      K_BR:    v = V_BR | V_SUB;
      K_JAL:   v = V_JMP | V_S1 | V_S2;
      K_JALR:  v = V_JMP | V_S2;
      K_MD:    v = V_MDS;
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic step(input string tag, input logic [2:0] st, input logic [16:0] ev,
                      input logic [16:0] mask, input logic ir, input logic dr, input logic md);
    IMEM_Ready = ir;
    DMEM_Ready = dr;
    MD_Done    = md;
    @(negedge CLK);
    check_eq({tag, "_state"}, 32'(state), 32'(st));
    check_eq({tag, "_ctrl"}, 32'(ctrl & mask), 32'(ev & mask));
    check_eq({tag, "_undef"}, 32'(undef_instr), 32'(undef_exp));
    check_eq({tag, "_buserr"}, 32'(bus_err), 32'(bus_exp));
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    undef_exp = 1'b0;
    bus_exp   = 1'b0;
    step("reset", 3'd0, 17'h0, FULL, rb(), rb(), rb());
    rst_n = 1'b1;
  endtask

  task automatic trap_cycles();
    for (int i = 0; i < trap_len; i++) step("trap", 3'd6, 17'h0, FULL, rb(), rb(), rb());
  endtask

  task automatic run_instr(input logic [6:0] op, input logic [6:0] f7, input logic [2:0] f3,
                           input int iw, input int dw, input int mw, input int md_rst);
    kind_t k = classify(op, f7);
    logic [16:0] mv;
    for (int i = 0; i < iw && i < 15; i++) begin
      Opcode = 7'($urandom);
      Funct7 = 7'($urandom);
      Funct3 = 3'($urandom);
      step("fetch_wait", 3'd0, V_IREQ, FULL, 1'b0, rb(), rb());
    end
    if (iw >= 15) begin
      bus_exp = 1'b1;
      trap_cycles();
      do_reset();
      return;
    end
    Opcode = op;
    Funct7 = f7;
    Funct3 = f3;
    step("fetch_rdy", 3'd0, V_IREQ | V_IRWR | V_PCWR, FULL, 1'b1, rb(), rb());
    step("decode", 3'd1, 17'h0, FULL, rb(), rb(), rb());
    if (k == K_ILL) begin
      undef_exp = 1'b1;
      trap_cycles();
      do_reset();
      return;
    end
    step("exec", 3'd2, exec_vec(k, f7, f3), (k == K_MD) ? M_MASK : FULL, rb(), rb(), rb());
    if (k == K_MD) begin
      check_eq("nom_state", 32'(state_b), 32'd6);
      check_eq("nom_undef", 32'(undef_instr_b), 32'd1);
    end
    case (k)
      K_LOAD, K_STORE: begin
        mv = V_DREQ | ((k == K_STORE) ? V_MWR : 17'h0);
        for (int i = 0; i < dw && i < 15; i++) step("mem_wait", 3'd3, mv, FULL, rb(), 1'b0, rb());
        if (dw >= 15) begin
          bus_exp = 1'b1;
          trap_cycles();
          do_reset();
          return;
        end
        step("mem_rdy", 3'd3, mv, FULL, rb(), 1'b1, rb());
        if (k == K_LOAD) step("wb", 3'd4, V_RWR | (17'd1 << 7), FULL, rb(), rb(), rb());
      end
      K_BR: ;
      K_MD: begin
        for (int i = 0; i < mw; i++) begin
          if (i == md_rst) begin
            do_reset();
            return;
          end
          step("md_wait", 3'd5, 17'h0, FULL, rb(), rb(), 1'b0);
        end
        step("md_done", 3'd5, 17'h0, FULL, rb(), rb(), 1'b1);
        step("wb", 3'd4, V_RWR | (17'd3 << 7), FULL, rb(), rb(), rb());
      end
      K_JAL, K_JALR: step("wb", 3'd4, V_RWR | (17'd2 << 7), FULL, rb(), rb(), rb());
      default: step("wb", 3'd4, V_RWR, FULL, rb(), rb(), rb());
    endcase
  endtask

  logic [6:0] ill_ops [4] = '{7'b0000000, 7'b1111111, 7'b0001111, 7'b1110011};

  initial begin
    rst_n = 1'b0;
    Opcode = '0; Funct7 = '0; Funct3 = '0;
    IMEM_Ready = 1'b0; DMEM_Ready = 1'b0; MD_Done = 1'b0;
    #1;
    do_reset();
    do_reset();

    run_instr(7'b0110011, 7'b0000000, 3'b000, 2, 0, 0, -1);
    run_instr(7'b0110011, 7'b0100000, 3'b000, 0, 0, 0, -1);
    run_instr(7'b0000011, 7'b0000000, 3'b010, 0, 2, 0, -1);
    run_instr(7'b0100011, 7'b0000000, 3'b010, 0, 0, 0, -1);
    run_instr(7'b1100011, 7'b0000000, 3'b000, 0, 0, 0, -1);
    run_instr(7'b0110011, 7'b0000001, 3'b000, 0, 0, 32, -1);
    trap_len = 20;
    run_instr(7'b0000000, 7'b0000000, 3'b000, 0, 0, 0, -1);
    trap_len = 3;
    run_instr(7'b0010011, 7'b0000000, 3'b000, 15, 0, 0, -1);
    run_instr(7'b0010011, 7'b0000000, 3'b011, 14, 0, 0, -1);
    run_instr(7'b0000011, 7'b0000000, 3'b000, 0, 15, 0, -1);
    run_instr(7'b0100011, 7'b0000000, 3'b000, 0, 14, 0, -1);
    run_instr(7'b0110011, 7'b0000001, 3'b100, 0, 0, 10, 4);
    run_instr(7'b1101111, 7'b0000000, 3'b000, 1, 0, 0, -1);

    for (int n = 0; n < 200; n++) begin
      kind_t k = kind_t'($urandom_range(0, 10));
      logic [6:0] op = opcode_of(k);
      logic [2:0] f3 = 3'($urandom);
      logic [6:0] f7 = 7'($urandom);
      int iw = ($urandom_range(0, 19) == 0) ? 15 : ($urandom_range(0, 9) == 0) ? 14 : $urandom_range(0, 3);
      int dw = ($urandom_range(0, 19) == 0) ? 15 : $urandom_range(0, 4);
      if (k == K_ALU) f7 = rb() ? 7'b0100000 : 7'b0000000;
      if (k == K_MD)  f7 = 7'b0000001;
      if (k == K_ILL) op = ill_ops[$urandom_range(0, 3)];
      run_instr(op, f7, f3, iw, dw, $urandom_range(0, 5), -1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
